mult8_error_sweeper: RTL and testbench
======================================

# mult8_error_sweeper

Exhaustive error-characterisation stage for the 8x8 approximate multiplier candidates.
- Drives every operand pair (A,B) ∈ [0,255]² into a combinational multiplier under test and consumes its 16-bit product.
- Computes the absolute error distance against the exact product.
- Accumulates error statistics the evolution loop uses for candidate fitness.
- Sits directly around the candidate multiplier: operands out, product back.

## Interface
Parameters:
- WIDTH, 8, operand width; product width is 2*WIDTH.
- ACC_W, 32, width of the summed-error accumulator.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  begin a sweep; sampled only in IDLE.
- stall  in  1  freeze operand advance for this cycle; only acts in SWEEP.
- mult_a  out  WIDTH  operand A to multiplier under test.
- mult_b  out  WIDTH  operand B to multiplier under test.
- mult_p  in  2*WIDTH  product returned combinationally, same cycle as mult_a/mult_b.
- busy  out  1  high in SWEEP and DRAIN.
- done  out  1  one-cycle pulse when results are final.
- err_count  out  2*WIDTH+1  number of pairs with nonzero error.
- sum_ed  out  ACC_W  Σ|A*B − mult_p|.
- max_ed  out  2*WIDTH  largest |A*B − mult_p|.
- max_a, max_b  out  WIDTH each  operands of the first pair reaching max_ed.

## Operation
- FSM states: IDLE, SWEEP, DRAIN, DONE.
  - IDLE, start=1: go to SWEEP; clear cnt, err_count, sum_ed, max_ed, max_a, max_b.
  - SWEEP: advance cnt (2*WIDTH bits) on every non-stalled cycle.
  - SWEEP, last pair (cnt=all-ones) accepted without stall: go to DRAIN.
  - DRAIN: 2 cycles.
  - DONE: 1 cycle, done=1, then IDLE.
- Operand mapping: mult_a=cnt[15:8], mult_b=cnt[7:0]. Both are driven from registered cnt, so they are glitch-free. They are 0 in IDLE, DRAIN and DONE.
- Pipeline:
  - S1 registers (a, b, mult_p, v1). v1=1 only for SWEEP cycles with stall=0.
  - S2 computes the exact product a*b. It registers ed=|exact−p| (unsigned, 16 bit), plus a, b and v2.
  - S3: when v2=1:
    - err_count += (ed≠0)
    - sum_ed += ed (zero-extended)
    - if ed > max_ed (strictly greater): max_ed=ed, max_a=a, max_b=b.
- Ties keep the earliest pair in sweep order.
- Overflow is not possible at defaults: maximum sum_ed is 65536·65535 < 2³². sum_ed wraps modulo 2^ACC_W for smaller ACC_W.
- start while busy or in DONE: ignored.
- stall in IDLE, DRAIN or DONE: ignored.
- Result outputs hold their values after DONE until the next accepted start.

## Timing
- Reset (rst_n=0, any state, including mid-sweep): FSM=IDLE, cnt=0, v1=v2=0. All outputs are 0: mult_a, mult_b, busy, done, err_count, sum_ed, max_ed, max_a, max_b.
- Let edge k be the edge where start is accepted.
  - busy=1 from edge k.
  - Pair 0 is on mult_a/mult_b during cycle k..k+1.
- With S stalled SWEEP cycles:
  - Last pair is captured into S1 at edge k+65536+S.
  - S3 final update happens at edge k+65538+S.
  - done=1 and busy=0 from edge k+65538+S for exactly one cycle.
- A stall cycle repeats the current operands. S1 drops that sample (v1=0), so each pair is counted exactly once.
- S2 and S3 keep draining during stalls.
- New start is accepted no earlier than the edge after done.

## Test plan
- **Exact model** (mult_p=A*B), start with no stall → err_count=0, sum_ed=0, max_ed=0, max_a=0, max_b=0; done at start edge+65538.
- **LSB-truncating model** (mult_p=(A*B)&16'hFFFE) → err_count=16384, sum_ed=16384, max_ed=1, max_a=1, max_b=1.
- **Zero model** (mult_p=0):
  - err_count=65025, sum_ed=1065369600, max_ed=65025, max_a=255, max_b=255.
  - Tie check: no earlier pair equals 65025.
- **Random 25% stall with the zero model** → results identical to the previous case; done latency = 65538 + number of stalled SWEEP cycles.
- **Reset mid-sweep**: rst_n low during SWEEP at cnt≈1000 → every output 0 on the asserting edge. Then restart with the LSB-truncating model → results match that case.
- **start pulses while busy, and stall in IDLE** → no restart, no effect; a start held high for 3 cycles in IDLE launches exactly one sweep.

Source files
------------

// File: rtl/mult8_error_sweeper_if.sv
// Operand/product link between the error sweeper and the combinational multiplier under test.
// The sweeper owns the operands; the multiplier answers with the product in the same cycle.
interface mult8_error_sweeper_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0]   mult_a;
    logic [WIDTH-1:0]   mult_b;
    logic [2*WIDTH-1:0] mult_p;

    modport master (output mult_a, output mult_b, input  mult_p);
    modport slave  (input  mult_a, input  mult_b, output mult_p);
endinterface

// File: rtl/mult8_error_sweeper.sv
// Sweeps all (A,B) pairs through a candidate multiplier and accumulates |A*B - P| statistics.
// Results final 2 cycles after the last pair is captured; stall freezes operand advance only.
module mult8_error_sweeper #(
    parameter int WIDTH = 8,
    parameter int ACC_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stall,
    mult8_error_sweeper_if.master mif,
    output logic                  busy,
    output logic                  done,
    output logic [2*WIDTH:0]      err_count,
    output logic [ACC_W-1:0]      sum_ed,
    output logic [2*WIDTH-1:0]    max_ed,
    output logic [WIDTH-1:0]      max_a,
    output logic [WIDTH-1:0]      max_b
);
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] cnt;
    logic          drain_cnt;
    logic          start_acc;
    logic          step;

    logic             v1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic [PW-1:0]    p1;

    logic             v2;
    logic [WIDTH-1:0] a2;
    logic [WIDTH-1:0] b2;
    logic [PW-1:0]    ed2;

    logic [PW-1:0] exact;
    logic [PW-1:0] ed_nxt;

    assign start_acc = (state == IDLE) && start;
    assign step      = (state == SWEEP) && !stall;

    // cnt wraps back to zero on the last pair, so the operands read 0 outside SWEEP
    assign mif.mult_a = cnt[PW-1:WIDTH];
    assign mif.mult_b = cnt[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SWEEP;
            SWEEP:   if (step && (cnt == '1)) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == SWEEP) || (state == DRAIN);
        done = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            drain_cnt <= 1'b0;
        end else begin
            if (start_acc) begin
                cnt <= '0;
            end else if (step) begin
                cnt <= cnt + 1'b1;
            end
            drain_cnt <= (state == DRAIN) && !drain_cnt;
        end
    end

    // S1: capture operands and returned product; stalled cycles carry no sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            a1 <= '0;
            b1 <= '0;
            p1 <= '0;
        end else begin
            v1 <= step;
            a1 <= cnt[PW-1:WIDTH];
            b1 <= cnt[WIDTH-1:0];
            p1 <= mif.mult_p;
        end
    end

    assign exact  = PW'(a1) * PW'(b1);
    assign ed_nxt = (exact >= p1) ? (exact - p1) : (p1 - exact);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2  <= 1'b0;
            a2  <= '0;
            b2  <= '0;
            ed2 <= '0;
        end else begin
            v2  <= v1;
            a2  <= a1;
            b2  <= b1;
            ed2 <= ed_nxt;
        end
    end

    // S3: strict > keeps the earliest pair in sweep order on ties
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
            sum_ed    <= '0;
            max_ed    <= '0;
            max_a     <= '0;
            max_b     <= '0;
        end else if (start_acc) begin
            err_count <= '0;
            sum_ed    <= '0;
            max_ed    <= '0;
            max_a     <= '0;
            max_b     <= '0;
        end else if (v2) begin
            err_count <= err_count + {{PW{1'b0}}, (ed2 != '0)};
            sum_ed    <= sum_ed + ACC_W'(ed2);
            if (ed2 > max_ed) begin
                max_ed <= ed2;
                max_a  <= a2;
                max_b  <= b2;
            end
        end
    end

endmodule

// File: tb/tb_mult8_error_sweeper.sv
// Scoreboard bench: reference statistics come from a plain double loop over all operand pairs.
`timescale 1ns/1ps
module tb_mult8_error_sweeper;
    localparam int W  = 4;
    localparam int AW = 32;
    localparam int PW = 2 * W;
    localparam int NP = 1 << PW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stall = 1'b0;
    logic          busy;
    logic          done;
    logic [PW:0]   err_count;
    logic [AW-1:0] sum_ed;
    logic [PW-1:0] max_ed;
    logic [W-1:0]  max_a;
    logic [W-1:0]  max_b;

    int          mode = 0;
    int unsigned k1 = 0, k2 = 0, k3 = 0;
    int          edge_cnt = 0;
    int          done_seen = 0;
    logic        prev_done = 1'b0;
    int          n_vec = 0;
    int          n_bad = 0;

    typedef struct {
        longint err;
        longint sum;
        longint mx;
        longint ma;
        longint mb;
        longint done_edge;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    mult8_error_sweeper_if #(.WIDTH(W)) mif ();

    mult8_error_sweeper #(.WIDTH(W), .ACC_W(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stall     (stall),
        .mif       (mif.master),
        .busy      (busy),
        .done      (done),
        .err_count (err_count),
        .sum_ed    (sum_ed),
        .max_ed    (max_ed),
        .max_a     (max_a),
        .max_b     (max_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Candidate multipliers: exact, LSB-dropping, constant zero, keyed random error
    function automatic int unsigned cand(int md, int unsigned a, int unsigned b,
                                         int unsigned q1, int unsigned q2, int unsigned q3);
        int unsigned x;
        x = a * b;
        case (md)
            0:       return x;
            1:       return x & ~32'd1;
            2:       return 0;
            default: return (x ^ ((a * q1 + b * q2) & q3)) % NP;
        endcase
    endfunction

    assign mif.mult_p = PW'(cand(mode, 32'(mif.mult_a), 32'(mif.mult_b), k1, k2, k3));

    function automatic exp_t ref_model(int md);
        exp_t   r;
        longint d;
        r = '{default: 0};
        for (int a = 0; a < (1 << W); a++) begin
            for (int b = 0; b < (1 << W); b++) begin
                d = longint'(a * b) - longint'(cand(md, a, b, k1, k2, k3));
                if (d < 0) d = -d;
                if (d != 0) r.err++;
                r.sum = (r.sum + d) % (longint'(1) << AW);
                if (d > r.mx) begin
                    r.mx = d;
                    r.ma = a;
                    r.mb = b;
                end
            end
        end
        return r;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_zero(string tag);
        chk({tag, "_mult_a"}, 64'(mif.mult_a), 0);
        chk({tag, "_mult_b"}, 64'(mif.mult_b), 0);
        chk({tag, "_busy"}, 64'(busy), 0);
        chk({tag, "_done"}, 64'(done), 0);
        chk({tag, "_err_count"}, 64'(err_count), 0);
        chk({tag, "_sum_ed"}, 64'(sum_ed), 0);
        chk({tag, "_max_ed"}, 64'(max_ed), 0);
        chk({tag, "_max_a"}, 64'(max_a), 0);
        chk({tag, "_max_b"}, 64'(max_b), 0);
    endtask

    // Monitor: pops the oldest expectation on every done pulse
    always @(negedge clk) begin
        if (rst_n && done) begin
            done_seen++;
            chk("done_one_cycle", 64'(prev_done), 0);
            chk("busy_at_done", 64'(busy), 0);
            if (sbq.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                mon_e = sbq.pop_front();
                chk("done_edge", 64'(edge_cnt), 64'(mon_e.done_edge));
                chk("err_count", 64'(err_count), 64'(mon_e.err));
                chk("sum_ed", 64'(sum_ed), 64'(mon_e.sum));
                chk("max_ed", 64'(max_ed), 64'(mon_e.mx));
                chk("max_a", 64'(max_a), 64'(mon_e.ma));
                chk("max_b", 64'(max_b), 64'(mon_e.mb));
            end
        end
        prev_done = done;
    end

    task automatic run_sweep(int md, int stall_pct, int hold, bit pulse, int abort_at);
        bit   stq[$];
        int   acc;
        int   s;
        int   idx;
        int   seen0;
        bit   got;
        exp_t e;
        acc = 0;
        s   = 0;
        while (acc < NP) begin
            stq.push_back($urandom_range(0, 99) < stall_pct);
            if (stq[stq.size()-1]) s++;
            else acc++;
        end
        @(negedge clk);
        mode  = md;
        e     = ref_model(md);
        start = 1'b1;
        stall = 1'($urandom);
        e.done_edge = longint'(edge_cnt + 1 + NP + s + 2);
        sbq.push_back(e);
        idx = 0;
        for (int i = 0; i < stq.size(); i++) begin
            @(negedge clk);
            if (i == 0) chk("busy_in_sweep", 64'(busy), 1);
            chk("mult_a_seq", 64'(mif.mult_a), 64'(idx >> W));
            chk("mult_b_seq", 64'(mif.mult_b), 64'(idx % (1 << W)));
            if (i == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_zero("rst_mid");
                void'(sbq.pop_back());
                stall = 1'b0;
                start = 1'b0;
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            stall = stq[i];
            start = ((i + 1) < hold) || (pulse && ($urandom_range(0, 7) == 0));
            if (!stq[i]) idx++;
        end
        seen0 = done_seen;
        @(negedge clk);
        stall = 1'b1;
        start = 1'b0;
        got = 1'b0;
        for (int t = 0; t < 10 && !got; t++) begin
            @(negedge clk);
            stall = 1'($urandom);
            if (done_seen > seen0) got = 1'b1;
        end
        if (!got) chk("done_timeout", 0, 1);
        repeat (3) @(negedge clk);
        stall = 1'b0;
        chk("hold_busy", 64'(busy), 0);
        chk("hold_err_count", 64'(err_count), 64'(e.err));
        chk("hold_sum_ed", 64'(sum_ed), 64'(e.sum));
        chk("hold_max_ed", 64'(max_ed), 64'(e.mx));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            stall = 1'($urandom);
            chk("idle_stall_busy", 64'(busy), 0);
            chk("idle_stall_mult_a", 64'(mif.mult_a), 0);
        end
        stall = 1'b0;
        run_sweep(0, 0, 3, 1'b0, -1);
        run_sweep(1, 0, 1, 1'b1, -1);
        run_sweep(2, 0, 1, 1'b0, -1);
        run_sweep(2, 25, 1, 1'b1, -1);
        run_sweep(1, 0, 1, 1'b0, 100);
        run_sweep(1, 0, 1, 1'b0, -1);
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            k1 = $urandom;
            k2 = $urandom;
            k3 = $urandom;
            run_sweep(3, 25, 1, 1'b1, -1);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            stall = 1'($urandom);
            chk("final_idle_done", 64'(done), 0);
            chk("final_idle_busy", 64'(busy), 0);
        end
        chk("scoreboard_empty", 64'(sbq.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
